bats_pitch_packetizer: RTL and testbench
========================================

# bats_pitch_packetizer

Transmit-side counterpart of the BATS PITCH parser: accepts one order-book command at a time and emits it as a framed PITCH packet (Sequenced Unit Header plus exactly one message) on a 64-bit word stream with byte enables. The output uses the same word and byte-lane format that the parser consumes, so the two blocks connect back-to-back for loopback test and market-data replay. It sits between a command source (replay logic or a host FIFO) and the UDP transmit path.

## Interface
Parameters:
- UNIT, default 8'd1: value of the Hdr Unit field.
- SEQ_START, default 32'd1: sequence number used after reset or `in_seq_clear`.

Ports:
- Clk40, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- in_cmd_valid, in, 1: command present.
- out_cmd_ready, out, 1: block can accept a command.
- in_cmd_type, in, 8: 0 = Time, 1 = Delete Order, 2 = Order Executed; any other value is unsupported.
- in_seconds_u32, in, 32: Time message seconds.
- in_time_offset_u32, in, 32: nanosecond offset for Delete and Executed.
- in_order_id_u64, in, 64: order id for Delete and Executed.
- in_executed_quantity_u32, in, 32: executed shares for Executed.
- in_execution_id_u64, in, 64: execution id for Executed.
- in_seq_clear, in, 1: the next packet uses SEQ_START.
- in_ready_for_udp_output, in, 1: downstream can accept a word.
- out_data_valid, out, 1: a word is presented.
- out_bytes, out, 64: the word; byte lane 0 is bits [63:56].
- out_byte_enables, out, 8: bit 7 qualifies lane 0; the enabled lanes are always a contiguous MSB-first run.
- out_last, out, 1: marks the final word of the packet.
- out_bad_cmd, out, 1: one-cycle pulse when an unsupported type is accepted.

## Operation
- Message formats. All multi-byte fields are little-endian. Byte 0 is Length, byte 1 is Type.
  - Time: length 6, type 0x20, then seconds u32.
  - Delete Order: length 14, type 0x29, then offset u32, then order id u64.
  - Order Executed: length 26, type 0x23, then offset u32, order id u64, executed quantity u32, execution id u64.
- Header, 8 bytes:
  - Hdr Length u16 = 8 + message length. This gives 14, 22 and 34 bytes total.
  - Hdr Count u8 = 1.
  - Hdr Unit u8 = UNIT.
  - Hdr Sequence u32 = current sequence number.
- Packet sizes:
  - Time: 2 words; last-word enables 8'b11111100.
  - Delete Order: 3 words; last-word enables 8'b11111100.
  - Order Executed: 5 words; last-word enables 8'b11000000.
- Padding: unused lanes in the last word are driven to 0.
- State machine:
  - IDLE: out_cmd_ready = 1. On the in_cmd_valid & out_cmd_ready handshake, latch all fields and the current sequence number into the packet buffer, then go to SEND.
  - Unsupported type on handshake: stay in IDLE, pulse out_bad_cmd for one cycle, leave the sequence number unchanged.
  - SEND: present word k. A word transfers on out_data_valid & in_ready_for_udp_output. After a transfer without out_last, advance k. After the transfer with out_last, go to IDLE.
- Sequence number:
  - Increments by 1 when a supported command is accepted.
  - Wraps from 0xFFFFFFFF to 0x00000000.
  - in_seq_clear sets the next-sequence register to SEQ_START in any state; a packet already latched keeps its own sequence value.
  - If in_seq_clear and an accept occur in the same cycle, the accepted packet uses SEQ_START and the next-sequence register becomes SEQ_START+1.
- Reset:
  - All outputs read 0 after the reset edge; out_cmd_ready reads 1 from the first cycle after reset is released.
  - Next-sequence register is set to SEQ_START.
  - Reset asserted mid-packet abandons the packet; no further words of it are emitted.

## Timing
- Accept at edge T; word 0 is valid starting with the cycle after edge T.
- Words come out back-to-back while in_ready_for_udp_output = 1.
- Stall: out_data_valid stays high, and out_bytes, out_byte_enables and out_last stay stable until the word transfers.
- out_cmd_ready = 0 from the accept edge until the edge of the last-word transfer; it is 1 again in the cycle that follows.
- Throughput: an N-word packet occupies N+1 cycles when there are no stalls.
- out_bad_cmd is high in the cycle after the accept edge.

## Structure
- Package bats_pitch_pkg:
  - Message type constants: 0x20, 0x29, 0x23.
  - Message length constants: 6, 14, 26.
  - Header length constant: 8.
  - Command type enum.
  - State enum.
- Top module: command latch, sequence counter, header and message byte assembly, FSM.
- Sub-module bats_word_serializer: takes a 40-byte buffer plus total byte count and emits words, byte enables and last under valid/ready.

## Test plan
1. Time 34200, seq 1, UNIT 1 -> two words:
   - 0x0E00010101000000, enables 0xFF.
   - 0x0620988500000000, enables 0xFC, out_last = 1.
2. Delete, offset 0x10, order id 0x0102030405060708, seq 2 -> three words:
   - 0x1600010102000000, 0xFF.
   - 0x0E29100000000807, 0xFF.
   - 0x0605040302010000, 0xFC, out_last = 1.
3. Order Executed -> 5 words:
   - Word 0 begins 0x2200.
   - Last-word enables 0xC0.
   - Hold in_ready_for_udp_output low for 3 cycles at word 2; that word stays stable with out_data_valid high.
4. Type 7 -> out_bad_cmd pulses once and no words are emitted; a following Time packet carries the sequence number that was expected before the bad command.
5. Sequence wrap: force next sequence to 0xFFFFFFFF and send two Time packets -> header sequences 0xFFFFFFFF, then 0x00000000.
6. Reset asserted at word 1 of a Delete packet:
   - Outputs read 0 on the next cycle.
   - out_cmd_ready returns after reset is released.
   - The next packet carries seq SEQ_START.
   - A loopback check feeds the output into the parser and requires out_ip_seconds_u64 = 34200.

Source files
------------

// File: rtl/bats_pitch_pkg.sv
// Shared constants and types for the BATS PITCH transmit packetizer.
// Wire format matches the receive-side parser byte for byte.
package bats_pitch_pkg;

  localparam logic [7:0] MSG_TIME   = 8'h20;
  localparam logic [7:0] MSG_DELETE = 8'h29;
  localparam logic [7:0] MSG_EXEC   = 8'h23;

  localparam logic [7:0] LEN_TIME   = 8'd6;
  localparam logic [7:0] LEN_DELETE = 8'd14;
  localparam logic [7:0] LEN_EXEC   = 8'd26;

  localparam logic [7:0] HDR_LEN    = 8'd8;
  localparam int         BUF_BYTES  = 40;

  typedef enum logic [7:0] {
    CMD_TIME   = 8'd0,
    CMD_DELETE = 8'd1,
    CMD_EXEC   = 8'd2
  } cmd_t;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  typedef logic [0:BUF_BYTES-1][7:0] pkt_t;

endpackage

// File: rtl/bats_word_serializer.sv
// Slices a latched byte buffer into 64-bit MSB-lane-first words.
// Unused lanes and all outputs read 0 while no word is presented.
module bats_word_serializer
  import bats_pitch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        ready,
  input  pkt_t        pkt,
  input  logic [5:0]  len,
  output logic [63:0] bytes,
  output logic [7:0]  enables,
  output logic        last,
  output logic        xfer
);

  logic [2:0] k;
  logic [5:0] base;

  assign base = {k, 3'b000};
  assign xfer = valid & ready;

  always_comb begin
    bytes   = '0;
    enables = '0;
    last    = 1'b0;
    if (valid) begin
      last = (base + 6'd8) >= len;
      for (int i = 0; i < 8; i++) begin
        if ((base + 6'(i)) < len) begin
          enables[7-i]         = 1'b1;
          bytes[63-8*i -: 8]   = pkt[base + 6'(i)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      k <= '0;
    else if (xfer)
      k <= last ? 3'd0 : k + 3'd1;
  end

endmodule

// File: rtl/bats_pitch_packetizer.sv
// Frames one order-book command per packet: Sequenced Unit Header
// plus a single Time, Delete Order or Order Executed message.
module bats_pitch_packetizer
  import bats_pitch_pkg::*;
#(
  parameter logic [7:0]  UNIT      = 8'd1,
  parameter logic [31:0] SEQ_START = 32'd1
) (
  input  logic        Clk40,
  input  logic        reset,
  input  logic        in_cmd_valid,
  output logic        out_cmd_ready,
  input  logic [7:0]  in_cmd_type,
  input  logic [31:0] in_seconds_u32,
  input  logic [31:0] in_time_offset_u32,
  input  logic [63:0] in_order_id_u64,
  input  logic [31:0] in_executed_quantity_u32,
  input  logic [63:0] in_execution_id_u64,
  input  logic        in_seq_clear,
  input  logic        in_ready_for_udp_output,
  output logic        out_data_valid,
  output logic [63:0] out_bytes,
  output logic [7:0]  out_byte_enables,
  output logic        out_last,
  output logic        out_bad_cmd
);

  state_t      state, state_nx;
  pkt_t        pkt, asm_pkt;
  logic [5:0]  len;
  logic [31:0] seq_next, seq_use;
  logic [15:0] hdr_len;
  logic [7:0]  msg_len, msg_type;
  logic        supported, accept, xfer, last, bad;

  // A clear coincident with an accept applies to that very packet.
  assign seq_use = in_seq_clear ? SEQ_START : seq_next;
  assign hdr_len = {8'd0, HDR_LEN + msg_len};

  always_comb begin
    supported = 1'b1;
    msg_len   = LEN_TIME;
    msg_type  = MSG_TIME;
    asm_pkt   = '0;
    case (in_cmd_type)
      CMD_TIME: begin
        for (int i = 0; i < 4; i++)
          asm_pkt[10+i] = in_seconds_u32[8*i +: 8];
      end
      CMD_DELETE, CMD_EXEC: begin
        msg_len  = (in_cmd_type == CMD_EXEC) ? LEN_EXEC : LEN_DELETE;
        msg_type = (in_cmd_type == CMD_EXEC) ? MSG_EXEC : MSG_DELETE;
        for (int i = 0; i < 4; i++)
          asm_pkt[10+i] = in_time_offset_u32[8*i +: 8];
        for (int i = 0; i < 8; i++)
          asm_pkt[14+i] = in_order_id_u64[8*i +: 8];
        if (in_cmd_type == CMD_EXEC) begin
          for (int i = 0; i < 4; i++)
            asm_pkt[22+i] = in_executed_quantity_u32[8*i +: 8];
          for (int i = 0; i < 8; i++)
            asm_pkt[26+i] = in_execution_id_u64[8*i +: 8];
        end
      end
      default: supported = 1'b0;
    endcase
    asm_pkt[0] = hdr_len[7:0];
    asm_pkt[1] = hdr_len[15:8];
    asm_pkt[2] = 8'd1;
    asm_pkt[3] = UNIT;
    for (int i = 0; i < 4; i++)
      asm_pkt[4+i] = seq_use[8*i +: 8];
    asm_pkt[8] = msg_len;
    asm_pkt[9] = msg_type;
  end

  always_comb begin
    state_nx      = state;
    out_cmd_ready = (state == S_IDLE) && !reset;
    accept        = in_cmd_valid && out_cmd_ready;
    unique case (state)
      S_IDLE: if (accept && supported) state_nx = S_SEND;
      S_SEND: if (xfer && last)        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk40) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge Clk40) begin
    if (reset) begin
      seq_next <= SEQ_START;
      bad      <= 1'b0;
      len      <= '0;
      pkt      <= '0;
    end else begin
      bad <= accept && !supported;
      if (accept && supported) begin
        pkt      <= asm_pkt;
        len      <= hdr_len[5:0];
        seq_next <= seq_use + 32'd1;
      end else if (in_seq_clear) begin
        seq_next <= SEQ_START;
      end
    end
  end

  assign out_data_valid = (state == S_SEND);
  assign out_last       = last;
  assign out_bad_cmd    = bad;

  bats_word_serializer u_ser (
    .clk     (Clk40),
    .reset   (reset),
    .valid   (out_data_valid),
    .ready   (in_ready_for_udp_output),
    .pkt     (pkt),
    .len     (len),
    .bytes   (out_bytes),
    .enables (out_byte_enables),
    .last    (last),
    .xfer    (xfer)
  );

endmodule

// File: tb/tb_bats_pitch_packetizer.sv
// Directed scoreboard bench for bats_pitch_packetizer, including a
// second instance started near the sequence wrap point.
module tb_bats_pitch_packetizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cmd_valid, w_cmd_valid, seq_clear, udp_ready;
  logic [7:0]  cmd_type;
  logic [31:0] secs, offs, qty;
  logic [63:0] oid, eid;

  logic        m_ready, m_dv, m_last, m_bad;
  logic [63:0] m_bytes;
  logic [7:0]  m_be;
  logic        w_ready, w_dv, w_last, w_bad;
  logic [63:0] w_bytes;
  logic [7:0]  w_be;

  logic        sel;
  logic        o_ready, o_dv, o_last;
  logic [63:0] o_bytes;
  logic [7:0]  o_be;

  assign o_ready = sel ? w_ready : m_ready;
  assign o_dv    = sel ? w_dv    : m_dv;
  assign o_last  = sel ? w_last  : m_last;
  assign o_bytes = sel ? w_bytes : m_bytes;
  assign o_be    = sel ? w_be    : m_be;

  bats_pitch_packetizer u_dut (
    .Clk40                    (clk),
    .reset                    (reset),
    .in_cmd_valid             (cmd_valid),
    .out_cmd_ready            (m_ready),
    .in_cmd_type              (cmd_type),
    .in_seconds_u32           (secs),
    .in_time_offset_u32       (offs),
    .in_order_id_u64          (oid),
    .in_executed_quantity_u32 (qty),
    .in_execution_id_u64      (eid),
    .in_seq_clear             (seq_clear),
    .in_ready_for_udp_output  (udp_ready),
    .out_data_valid           (m_dv),
    .out_bytes                (m_bytes),
    .out_byte_enables         (m_be),
    .out_last                 (m_last),
    .out_bad_cmd              (m_bad)
  );

  bats_pitch_packetizer #(.SEQ_START(32'hFFFF_FFFF)) u_wrap (
    .Clk40                    (clk),
    .reset                    (reset),
    .in_cmd_valid             (w_cmd_valid),
    .out_cmd_ready            (w_ready),
    .in_cmd_type              (cmd_type),
    .in_seconds_u32           (secs),
    .in_time_offset_u32       (offs),
    .in_order_id_u64          (oid),
    .in_executed_quantity_u32 (qty),
    .in_execution_id_u64      (eid),
    .in_seq_clear             (seq_clear),
    .in_ready_for_udp_output  (udp_ready),
    .out_data_valid           (w_dv),
    .out_bytes                (w_bytes),
    .out_byte_enables         (w_be),
    .out_last                 (w_last),
    .out_bad_cmd              (w_bad)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  be;
    logic        last;
  } word_t;

  word_t       q[$];
  logic [63:0] rx[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_seq;
  logic [31:0] dec;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] d, input logic [7:0] be,
                           input logic l);
    word_t w;
    w.d = d; w.be = be; w.last = l;
    q.push_back(w);
  endtask

  // Reference byte image built straight from the message layout.
  task automatic push_model(input int t, input logic [31:0] seq);
    logic [7:0]  b [40];
    int          n, ml, nw;
    logic [63:0] d;
    logic [7:0]  be;
    for (int i = 0; i < 40; i++) b[i] = 8'h00;
    ml = (t == 0) ? 6 : (t == 1) ? 14 : 26;
    n  = 8 + ml;
    b[0] = 8'(n); b[1] = 8'h00; b[2] = 8'h01; b[3] = 8'h01;
    for (int i = 0; i < 4; i++) b[4+i] = seq[8*i +: 8];
    b[8] = 8'(ml);
    b[9] = (t == 0) ? 8'h20 : (t == 1) ? 8'h29 : 8'h23;
    if (t == 0) begin
      for (int i = 0; i < 4; i++) b[10+i] = secs[8*i +: 8];
    end else begin
      for (int i = 0; i < 4; i++) b[10+i] = offs[8*i +: 8];
      for (int i = 0; i < 8; i++) b[14+i] = oid[8*i +: 8];
      if (t == 2) begin
        for (int i = 0; i < 4; i++) b[22+i] = qty[8*i +: 8];
        for (int i = 0; i < 8; i++) b[26+i] = eid[8*i +: 8];
      end
    end
    nw = (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      d = '0; be = '0;
      for (int i = 0; i < 8; i++)
        if (8*w + i < n) begin
          be[7-i] = 1'b1;
          d[63-8*i -: 8] = b[8*w + i];
        end
      push_word(d, be, w == nw - 1);
    end
  endtask

  task automatic send(input bit which, input logic [7:0] t, input bit clr);
    @(negedge clk);
    sel = which;
    #1;
    chk("cmd_ready_before_accept", o_ready, 1);
    cmd_type  = t;
    seq_clear = clr;
    if (which) w_cmd_valid = 1'b1;
    else       cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; w_cmd_valid = 1'b0; seq_clear = 1'b0;
  endtask

  task automatic run_pkt(input bit which, input int n, input int stall_word,
                         input int stall_cycles);
    int    got = 0;
    int    cyc = 0;
    int    st  = 0;
    word_t w;
    sel = which;
    rx.delete();
    while (got < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("first_word_latency", o_dv, 1);
      if (got == stall_word && st < stall_cycles) begin
        udp_ready = 1'b0;
        st++;
        chk("stall_valid", o_dv, 1);
        if (q.size() > 0) begin
          chk("stall_data", o_bytes, q[0].d);
          chk("stall_last", o_last, q[0].last);
        end
      end else begin
        udp_ready = 1'b1;
        if (o_dv && q.size() > 0) begin
          w = q.pop_front();
          chk("word_data", o_bytes, w.d);
          chk("word_enables", o_be, w.be);
          chk("word_last", o_last, w.last);
          rx.push_back(o_bytes);
          got++;
        end
      end
    end
    chk("packet_timeout", 64'(got), 64'(n));
    @(negedge clk);
    chk("idle_valid_after_last", o_dv, 0);
    chk("ready_after_last", o_ready, 1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; w_cmd_valid = 1'b0; seq_clear = 1'b0;
    udp_ready = 1'b1; cmd_type = '0; secs = '0; offs = '0; qty = '0;
    oid = '0; eid = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", m_dv, 0);
    chk("reset_bytes", m_bytes, 0);
    chk("reset_be", m_be, 0);
    chk("reset_ready", m_ready, 0);
    chk("reset_bad", m_bad, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", m_ready, 1);

    // 1: Time packet, spec literal words
    secs = 32'd34200;
    push_word(64'h0E00010101000000, 8'hFF, 1'b0);
    push_word(64'h0620988500000000, 8'hFC, 1'b1);
    send(0, 8'd0, 0);
    run_pkt(0, 2, -1, 0);

    // 2: Delete packet, spec literal words
    offs = 32'h10; oid = 64'h0102030405060708;
    push_word(64'h1600010102000000, 8'hFF, 1'b0);
    push_word(64'h0E29100000000807, 8'hFF, 1'b0);
    push_word(64'h0605040302010000, 8'hFC, 1'b1);
    send(0, 8'd1, 0);
    run_pkt(0, 3, -1, 0);

    // 3: Order Executed with 3-cycle stall at word 2
    offs = 32'hA1B2C3D4; oid = 64'h1122334455667788;
    qty = 32'd500; eid = 64'hCAFEBABE_DEADBEEF;
    push_model(2, 32'd3);
    chk("exec_hdr_prefix", {48'd0, q[0].d[63:48]}, 64'h2200);
    send(0, 8'd2, 0);
    run_pkt(0, 5, 2, 3);

    // 4: unsupported type leaves sequence untouched
    send(0, 8'd7, 0);
    @(negedge clk);
    chk("bad_pulse", m_bad, 1);
    chk("bad_no_valid", m_dv, 0);
    @(negedge clk);
    chk("bad_pulse_single", m_bad, 0);
    chk("bad_still_idle", m_dv, 0);
    secs = 32'd77;
    push_model(0, 32'd4);
    send(0, 8'd0, 0);
    run_pkt(0, 2, -1, 0);

    // seq clear coincident with accept, then +1
    secs = 32'd5;
    push_model(0, 32'd1);
    send(0, 8'd0, 1);
    run_pkt(0, 2, -1, 0);
    push_model(0, 32'd2);
    send(0, 8'd0, 0);
    run_pkt(0, 2, -1, 0);

    // 5: wrap instance starts at 0xFFFFFFFF
    secs = 32'd9;
    push_model(0, 32'hFFFF_FFFF);
    send(1, 8'd0, 0);
    run_pkt(1, 2, -1, 0);
    push_model(0, 32'h0000_0000);
    send(1, 8'd0, 0);
    run_pkt(1, 2, -1, 0);

    // 6: reset during word 1 of a Delete packet
    offs = 32'h22; oid = 64'h0A0B0C0D0E0F1011;
    send(0, 8'd1, 0);
    sel = 1'b0;
    @(negedge clk);
    chk("abort_word0_valid", m_dv, 1);
    udp_ready = 1'b1;
    @(negedge clk);
    chk("abort_word1_valid", m_dv, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_valid_zero", m_dv, 0);
    chk("abort_bytes_zero", m_bytes, 0);
    chk("abort_be_zero", m_be, 0);
    chk("abort_last_zero", m_last, 0);
    chk("abort_ready_zero", m_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", m_ready, 1);
    chk("abort_no_words", m_dv, 0);
    secs = 32'd34200;
    exp_seq = 32'd1;
    push_model(0, exp_seq);
    send(0, 8'd0, 0);
    run_pkt(0, 2, -1, 0);
    dec = 32'd0;
    if (rx.size() == 2)
      dec = {rx[1][23:16], rx[1][31:24], rx[1][39:32], rx[1][47:40]};
    chk("loopback_seconds", {32'd0, dec}, 64'd34200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
